// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module : isa_pkg
// Brief  : Shared MUL opcodes, NOP word, mul_type and dispatcher state codes.
// Rev    : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam logic [6:0]  c_OP_MULI  = 7'b0010011;
    localparam logic [6:0]  c_OP_MULR  = 7'b0110011;
    localparam logic [6:0]  c_OP_MULSI = 7'b0011011;
    localparam logic [6:0]  c_OP_MULSR = 7'b0111011;
    localparam logic [31:0] c_NOP      = {5'b11001, 27'b0};

    typedef enum logic [1:0] {
        MT_MULI  = 2'd0,
        MT_MULR  = 2'd1,
        MT_MULSI = 2'd2,
        MT_MULSR = 2'd3
    } mul_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_RESUME = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    function automatic logic is_mul(input logic [6:0] op);
        return op inside {c_OP_MULI, c_OP_MULR, c_OP_MULSI, c_OP_MULSR};
    endfunction

    function automatic mul_type_e mul_type_of(input logic [6:0] op);
        case (op)
            c_OP_MULR:  return MT_MULR;
            c_OP_MULSI: return MT_MULSI;
            c_OP_MULSR: return MT_MULSR;
            default:    return MT_MULI;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module : mul_dispatch_if
// Brief  : Dispatcher <-> microcode sequencer handshake and held MUL operands.
// Rev    : 1.0 - initial release
// ============================================================================
interface mul_dispatch_if;
    import isa_pkg::*;

    logic        start_mul;
    logic [3:0]  dest_reg;
    logic [3:0]  source_reg;
    logic [15:0] immediate;
    logic [31:0] readDataSecond;
    mul_type_e   mul_type;
    logic [3:0]  flags_to_ucode;
    logic [31:0] ucode_instr;
    logic        ucode_mux_ctrl;
    logic        ucode_release;
    logic [3:0]  ucode_flags;

    modport master (
        output start_mul, dest_reg, source_reg, immediate, readDataSecond, mul_type, flags_to_ucode,
        input  ucode_instr, ucode_mux_ctrl, ucode_release, ucode_flags
    );

    modport slave (
        input  start_mul, dest_reg, source_reg, immediate, readDataSecond, mul_type, flags_to_ucode,
        output ucode_instr, ucode_mux_ctrl, ucode_release, ucode_flags
    );
endinterface
`default_nettype wire

// File: rtl/mul_watchdog.sv
`default_nettype none
// ============================================================================
// Module : mul_watchdog
// Brief  : RUN-state cycle counter; expired flags the cycle the limit is hit.
// Rev    : 1.0 - initial release
// ============================================================================
module mul_watchdog (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clr,
    input  wire logic        en,
    input  wire logic [31:0] limit,
    output logic             expired
);
    logic [31:0] r_count;
    logic [31:0] w_count_inc;

    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
        end else if (clr) begin
            r_count <= 32'd0;
        end else if (en) begin
            r_count <= w_count_inc;
        end
    end

    // A zero limit disables the watchdog entirely.
    assign expired = en && (limit != 32'd0) && (w_count_inc >= limit);
endmodule
`default_nettype wire

// File: rtl/mul_dispatch.sv
`default_nettype none
// ============================================================================
// Module : mul_dispatch
// Brief  : Stalls fetch on a MUL, hands it to the microcode sequencer, resumes.
// Rev    : 1.0 - initial release
// ============================================================================
module mul_dispatch
    import isa_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd70000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] fetch_instr,
    input  wire logic        fetch_valid,
    input  wire logic [31:0] rs2_data,
    input  wire logic [3:0]  flags_exec,
    mul_dispatch_if.master   seq_if,
    output logic [31:0]      issue_instr,
    output logic             issue_valid,
    output logic             fetch_stall,
    output logic             flags_restore_en,
    output logic [3:0]       flags_restore,
    output logic             mul_timeout
);
    state_e      r_state;
    state_e      w_next;
    logic [3:0]  r_dest;
    logic [3:0]  r_src;
    logic [15:0] r_imm;
    logic [31:0] r_rs2;
    mul_type_e   r_mtype;
    logic [3:0]  r_flags;
    logic        r_timeout;
    logic        w_capture;
    logic        w_start;
    logic        w_set_timeout;
    logic        w_wd_clr;
    logic        w_wd_en;
    logic        w_wd_expired;
    logic [6:0]  w_opcode;
    logic        w_fetch_mul;
    logic        w_unused_rs2_field;

    assign w_opcode           = fetch_instr[31:25];
    assign w_fetch_mul        = fetch_valid && is_mul(w_opcode);
    assign w_unused_rs2_field = fetch_instr[16];

    mul_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .limit   (TIMEOUT_CYCLES),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dest  <= 4'd0;
            r_src   <= 4'd0;
            r_imm   <= 16'd0;
            r_rs2   <= 32'd0;
            r_mtype <= MT_MULI;
            r_flags <= 4'd0;
        end else if (w_capture) begin
            r_dest  <= fetch_instr[24:21];
            r_src   <= fetch_instr[20:17];
            r_imm   <= fetch_instr[15:0];
            r_rs2   <= rs2_data;
            r_mtype <= mul_type_of(w_opcode);
            r_flags <= flags_exec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_next           = r_state;
        issue_instr      = c_NOP;
        issue_valid      = 1'b0;
        fetch_stall      = 1'b0;
        flags_restore_en = 1'b0;
        flags_restore    = 4'd0;
        w_capture        = 1'b0;
        w_start          = 1'b0;
        w_set_timeout    = 1'b0;
        w_wd_clr         = 1'b0;
        w_wd_en          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fetch_mul) begin
                    fetch_stall = 1'b1;
                    w_capture   = 1'b1;
                    w_next      = ST_LAUNCH;
                end else if (fetch_valid) begin
                    issue_instr = fetch_instr;
                    issue_valid = 1'b1;
                end
            end
            ST_LAUNCH: begin
                w_start     = 1'b1;
                fetch_stall = 1'b1;
                w_wd_clr    = 1'b1;
                w_next      = ST_RUN;
            end
            ST_RUN: begin
                fetch_stall = 1'b1;
                w_wd_en     = 1'b1;
                if (seq_if.ucode_mux_ctrl) begin
                    issue_instr = seq_if.ucode_instr;
                    issue_valid = 1'b1;
                end
                // Release outranks a coincident watchdog expiry.
                if (seq_if.ucode_release) begin
                    w_next = ST_RESUME;
                    if (r_mtype == MT_MULI || r_mtype == MT_MULR) begin
                        flags_restore_en = 1'b1;
                        flags_restore    = seq_if.ucode_flags;
                    end
                end else if (w_wd_expired) begin
                    w_set_timeout = 1'b1;
                    w_next        = ST_ERR;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Keep outputs quiet while reset is held even though IDLE would pass fetch through.
        if (!rst) begin
            issue_instr      = c_NOP;
            issue_valid      = 1'b0;
            fetch_stall      = 1'b0;
            flags_restore_en = 1'b0;
            flags_restore    = 4'd0;
            w_start          = 1'b0;
        end
    end

    assign seq_if.start_mul      = w_start;
    assign seq_if.dest_reg       = r_dest;
    assign seq_if.source_reg     = r_src;
    assign seq_if.immediate      = r_imm;
    assign seq_if.readDataSecond = r_rs2;
    assign seq_if.mul_type       = r_mtype;
    assign seq_if.flags_to_ucode = r_flags;
    assign mul_timeout           = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_mul_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_mul_dispatch
// Brief  : Directed, table-driven bench for mul_dispatch.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mul_dispatch;

    localparam logic [31:0] T_NOP   = {5'b11001, 27'b0};
    localparam logic [31:0] I_MULI  = 32'h2620_0003;  // MULI  R1,R0,#3
    localparam logic [31:0] I_MULR  = 32'h66A0_0000;  // MULR  R5,R0,R0
    localparam logic [31:0] I_MULSI = 32'h36E2_1234;  // MULSI R7,R1,#0x1234
    localparam logic [31:0] I_MULSR = 32'h7646_8000;  // MULSR R2,R3,R4
    localparam logic [31:0] I_ADD   = 32'h0231_2345;
    localparam logic [31:0] I_SUB   = 32'h0444_5678;
    localparam logic [31:0] I_NEAR  = 32'h2420_0003;  // opcode 0010010, not a MUL
    localparam logic [31:0] U_MOV   = 32'h0A20_0003;
    localparam logic [31:0] U_ADD   = 32'h0221_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic [31:0] rs2_data;
    logic [3:0]  flags_exec;
    logic [31:0] issue_instr;
    logic        issue_valid;
    logic        fetch_stall;
    logic        flags_restore_en;
    logic [3:0]  flags_restore;
    logic        mul_timeout;
    int          n_pass  = 0;
    int          n_total = 0;

    mul_dispatch_if u_if ();

    mul_dispatch #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_instr      (fetch_instr),
        .fetch_valid      (fetch_valid),
        .rs2_data         (rs2_data),
        .flags_exec       (flags_exec),
        .seq_if           (u_if),
        .issue_instr      (issue_instr),
        .issue_valid      (issue_valid),
        .fetch_stall      (fetch_stall),
        .flags_restore_en (flags_restore_en),
        .flags_restore    (flags_restore),
        .mul_timeout      (mul_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fi;
        logic        fv;
        logic        mux;
        logic        rel;
        logic [31:0] e_issue;
        logic        e_valid;
    } idle_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // One clock: drive just after the edge, compare mid-cycle.
    task automatic cyc(input string nm, input logic [31:0] fi, input logic fv, input logic mux,
                       input logic [31:0] ui, input logic rel, input logic [31:0] e_issue,
                       input logic e_valid, input logic e_stall, input logic e_start,
                       input logic e_ren, input logic e_tmo);
        @(posedge clk);
        #1;
        fetch_instr          = fi;
        fetch_valid          = fv;
        u_if.ucode_mux_ctrl  = mux;
        u_if.ucode_instr     = ui;
        u_if.ucode_release   = rel;
        #2;
        chk({nm, ".issue"}, issue_instr, e_issue);
        chk({nm, ".valid"}, 32'(issue_valid), 32'(e_valid));
        chk({nm, ".stall"}, 32'(fetch_stall), 32'(e_stall));
        chk({nm, ".start"}, 32'(u_if.start_mul), 32'(e_start));
        chk({nm, ".ren"}, 32'(flags_restore_en), 32'(e_ren));
        chk({nm, ".tmo"}, 32'(mul_timeout), 32'(e_tmo));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang, want finish");
        $fatal(1);
    end

    initial begin
        idle_vec_t tbl [6];
        tbl[0] = '{I_ADD,   1'b1, 1'b0, 1'b0, I_ADD,  1'b1};
        tbl[1] = '{I_SUB,   1'b1, 1'b1, 1'b1, I_SUB,  1'b1};
        tbl[2] = '{I_MULI,  1'b0, 1'b0, 1'b0, T_NOP,  1'b0};
        tbl[3] = '{I_NEAR,  1'b1, 1'b0, 1'b0, I_NEAR, 1'b1};
        tbl[4] = '{T_NOP,   1'b1, 1'b0, 1'b0, T_NOP,  1'b1};
        tbl[5] = '{I_ADD,   1'b0, 1'b1, 1'b1, T_NOP,  1'b0};

        // Reset with a live MUL and active sequencer inputs present.
        rst                 = 1'b0;
        fetch_instr         = I_MULI;
        fetch_valid         = 1'b1;
        rs2_data            = 32'h1234_5678;
        flags_exec          = 4'b1111;
        u_if.ucode_instr    = U_MOV;
        u_if.ucode_mux_ctrl = 1'b1;
        u_if.ucode_release  = 1'b1;
        u_if.ucode_flags    = 4'b1111;
        #12;
        chk("rst.issue", issue_instr, T_NOP);
        chk("rst.valid", 32'(issue_valid), 32'd0);
        chk("rst.stall", 32'(fetch_stall), 32'd0);
        chk("rst.start", 32'(u_if.start_mul), 32'd0);
        chk("rst.ren", 32'(flags_restore_en), 32'd0);
        chk("rst.rflags", 32'(flags_restore), 32'd0);
        chk("rst.tmo", 32'(mul_timeout), 32'd0);
        chk("rst.rds", u_if.readDataSecond, 32'd0);
        chk("rst.dest", 32'(u_if.dest_reg), 32'd0);
        chk("rst.imm", 32'(u_if.immediate), 32'd0);
        chk("rst.ftu", 32'(u_if.flags_to_ucode), 32'd0);
        fetch_valid         = 1'b0;
        u_if.ucode_mux_ctrl = 1'b0;
        u_if.ucode_release  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // IDLE pass-through and ignored sequencer inputs.
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].fi, tbl[i].fv, tbl[i].mux, 32'hDEAD_BEEF, tbl[i].rel,
                tbl[i].e_issue, tbl[i].e_valid, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // MULI R1,R0,#3 with MOV + 3 ADD + released NOP.
        flags_exec       = 4'b1010;
        rs2_data         = 32'h0000_0055;
        u_if.ucode_flags = 4'b1010;
        cyc("A.cap",    I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("A.launch", I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("A.dest", 32'(u_if.dest_reg), 32'd1);
        chk("A.src", 32'(u_if.source_reg), 32'd0);
        chk("A.imm", 32'(u_if.immediate), 32'd3);
        chk("A.mtype", 32'(u_if.mul_type), 32'd0);
        chk("A.ftu", 32'(u_if.flags_to_ucode), 32'b1010);
        chk("A.rds", u_if.readDataSecond, 32'h55);
        flags_exec = 4'b0000;
        rs2_data   = 32'd0;
        cyc("A.mov",  I_MULI, 1'b1, 1'b1, U_MOV, 1'b0, U_MOV, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("A.add1", I_MULI, 1'b1, 1'b1, U_ADD, 1'b0, U_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("A.add2", I_MULI, 1'b1, 1'b1, U_ADD, 1'b0, U_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("A.add3", I_MULI, 1'b1, 1'b1, U_ADD, 1'b0, U_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("A.rel",  I_MULI, 1'b1, 1'b1, T_NOP, 1'b1, T_NOP, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("A.rflags", 32'(flags_restore), 32'b1010);
        chk("A.ftu_held", 32'(u_if.flags_to_ucode), 32'b1010);
        chk("A.rds_held", u_if.readDataSecond, 32'h55);
        cyc("A.resume", I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("A.idle",   I_ADD,  1'b1, 1'b0, 32'd0, 1'b0, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // MULSR: S-form never restores flags.
        flags_exec       = 4'b0101;
        rs2_data         = 32'hFFFF_FFFE;
        u_if.ucode_flags = 4'b1111;
        cyc("B.cap",    I_MULSR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("B.launch", I_MULSR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("B.rds", u_if.readDataSecond, 32'hFFFF_FFFE);
        chk("B.mtype", 32'(u_if.mul_type), 32'd3);
        chk("B.dest", 32'(u_if.dest_reg), 32'd2);
        chk("B.src", 32'(u_if.source_reg), 32'd3);
        rs2_data = 32'd0;
        cyc("B.run",    I_MULSR, 1'b1, 1'b0, U_MOV, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("B.rel",    I_MULSR, 1'b1, 1'b0, U_MOV, 1'b1, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("B.rds_held", u_if.readDataSecond, 32'hFFFF_FFFE);
        cyc("B.resume", I_MULSR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release in the 16th RUN cycle, same cycle the watchdog would fire.
        u_if.ucode_flags = 4'b0011;
        cyc("D.cap",    I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("D.launch", I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("D.run%0d", i), I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc("D.rel",    I_MULI, 1'b1, 1'b0, 32'd0, 1'b1, T_NOP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("D.rflags", 32'(flags_restore), 32'b0011);
        cyc("D.resume", I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("D.idle",   I_ADD,  1'b1, 1'b0, 32'd0, 1'b0, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Sequencer never releases: ERR after 16 RUN cycles, sticky error.
        cyc("C.cap",    I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("C.launch", I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("C.run%0d", i), I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc("C.err",   I_MULR, 1'b0, 1'b1, U_MOV, 1'b1, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("C.idle1", I_ADD,  1'b1, 1'b0, 32'd0, 1'b0, I_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("C.idle2", I_SUB,  1'b1, 1'b0, 32'd0, 1'b0, I_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-RUN, then a fresh MULSI launches normally.
        cyc("E.cap",    I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("E.launch", I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("E.run",    I_MULR, 1'b1, 1'b1, U_MOV, 1'b0, U_MOV, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("E.rst.issue", issue_instr, T_NOP);
        chk("E.rst.valid", 32'(issue_valid), 32'd0);
        chk("E.rst.stall", 32'(fetch_stall), 32'd0);
        chk("E.rst.tmo", 32'(mul_timeout), 32'd0);
        chk("E.rst.dest", 32'(u_if.dest_reg), 32'd0);
        chk("E.rst.mtype", 32'(u_if.mul_type), 32'd0);
        fetch_valid         = 1'b0;
        u_if.ucode_mux_ctrl = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc("E.cap2",    I_MULSI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("E.launch2", I_MULSI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("E.dest", 32'(u_if.dest_reg), 32'd7);
        chk("E.src", 32'(u_if.source_reg), 32'd1);
        chk("E.imm", 32'(u_if.immediate), 32'h1234);
        chk("E.mtype", 32'(u_if.mul_type), 32'd2);
        cyc("E.rel",     I_MULSI, 1'b1, 1'b0, 32'd0, 1'b1, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("E.resume",  I_MULSI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back MULI then MULR.
        u_if.ucode_flags = 4'b0110;
        cyc("F.cap1",    I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("F.launch1", I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("F.rel1",    I_MULI, 1'b1, 1'b0, 32'd0, 1'b1, T_NOP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("F.resume1", I_MULI, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("F.cap2",    I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("F.launch2", I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("F.mtype", 32'(u_if.mul_type), 32'd1);
        chk("F.dest", 32'(u_if.dest_reg), 32'd5);
        cyc("F.rel2",    I_MULR, 1'b1, 1'b0, 32'd0, 1'b1, T_NOP, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("F.rflags", 32'(flags_restore), 32'b0110);
        cyc("F.resume2", I_MULR, 1'b1, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("F.idle",    I_ADD,  1'b0, 1'b0, 32'd0, 1'b0, T_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
